// File: rtl/ahb_decode_mux_if.sv
// AHB-Lite decode/mux bus bundle: master-side address/response plus the per-slave return paths.
interface ahb_decode_mux_if #(
  parameter int unsigned N_SLAVES = 3
);
  logic [31:0]            haddr;
  logic [1:0]             htrans;
  logic [N_SLAVES-1:0]    hsel;
  logic                   hready;
  logic [31:0]            hrdata;
  logic                   hresp;
  logic [N_SLAVES*32-1:0] s_hrdata;
  logic [N_SLAVES-1:0]    s_hreadyout;
  logic [N_SLAVES-1:0]    s_hresp;

  // Interconnect view
  modport slave (
    input  haddr, htrans, s_hrdata, s_hreadyout, s_hresp,
    output hsel, hready, hrdata, hresp
  );

  // Environment view: the bus master plus the slaves' return paths
  modport master (
    output haddr, htrans, s_hrdata, s_hreadyout, s_hresp,
    input  hsel, hready, hrdata, hresp
  );
endinterface

// File: rtl/ahb_decode_mux.sv
// AHB-Lite single-master interconnect: address decode, data-phase response mux,
// built-in ERROR default slave and optional wait-state watchdog.
module ahb_decode_mux #(
  parameter int unsigned            N_SLAVES       = 3,
  parameter logic [N_SLAVES*32-1:0] SLAVE_BASE     = {N_SLAVES{32'h0}},
  parameter logic [N_SLAVES*32-1:0] SLAVE_SIZE     = {N_SLAVES{32'h800}},
  parameter int unsigned            TIMEOUT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  ahb_decode_mux_if.slave   bus,
  output logic              timeout_evt
);

  localparam int unsigned       SEL_W   = $clog2(N_SLAVES + 1);
  localparam logic [SEL_W-1:0]  DEF     = SEL_W'(N_SLAVES);
  localparam bit                WD_EN   = (TIMEOUT_CYCLES > 0);
  localparam int unsigned       CNT_W   = WD_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0]  WD_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]  WD_LAST = CNT_W'(WD_EN ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {D_IDLE, D_ERR1, D_ERR2} def_state_t;
  typedef enum logic [1:0] {T_IDLE, T_ERR1, T_ERR2} wd_state_t;

  def_state_t          d_state, d_next;
  wd_state_t           t_state, t_next;
  logic [SEL_W-1:0]    dsel;
  logic                dvalid;
  logic [CNT_W-1:0]    wcnt;

  logic [N_SLAVES-1:0] slave_hit;
  logic                hit;
  logic [SEL_W-1:0]    hit_idx;
  logic [N_SLAVES-1:0] hsel_c;
  logic [31:0]         sel_rdata;
  logic                sel_ready;
  logic                sel_resp;
  logic                hready_c;
  logic                hresp_c;
  logic [31:0]         hrdata_c;
  logic                wd_active_c;
  logic                wd_fire_c;
  logic                accept_unmapped_c;
  logic                unused_htrans0;

  assign unused_htrans0 = bus.htrans[0];

  // Per-slave region compare, widened to 33 bits so base+size never wraps
  for (genvar g = 0; g < int'(N_SLAVES); g++) begin : g_dec
    localparam logic [32:0] LO = {1'b0, SLAVE_BASE[g*32 +: 32]};
    localparam logic [32:0] HI = LO + {1'b0, SLAVE_SIZE[g*32 +: 32]};
    assign slave_hit[g] = ({1'b0, bus.haddr} >= LO) && ({1'b0, bus.haddr} < HI);
  end

  // Priority select: scanning downward lets the lowest overlapping index win
  always_comb begin
    hit     = 1'b0;
    hit_idx = DEF;
    hsel_c  = '0;
    for (int i = int'(N_SLAVES) - 1; i >= 0; i--) begin
      if (slave_hit[i]) begin
        hit       = 1'b1;
        hit_idx   = SEL_W'(i);
        hsel_c    = '0;
        hsel_c[i] = 1'b1;
      end
    end
  end

  // Return path of the current data-phase owner
  always_comb begin
    sel_rdata = '0;
    sel_ready = 1'b1;
    sel_resp  = 1'b0;
    for (int i = 0; i < int'(N_SLAVES); i++) begin
      if (dsel == SEL_W'(i)) begin
        sel_rdata = bus.s_hrdata[i*32 +: 32];
        sel_ready = bus.s_hreadyout[i];
        sel_resp  = bus.s_hresp[i];
      end
    end
  end

  assign wd_active_c = WD_EN && dvalid && (dsel != DEF);
  assign wd_fire_c   = wd_active_c && (t_state == T_IDLE) && !sel_ready && (wcnt == WD_LAST);

  // Response mux: default slave, watchdog override, or slave pass-through
  always_comb begin
    hready_c = 1'b1;
    hresp_c  = 1'b0;
    hrdata_c = '0;
    if (dsel == DEF) begin
      hready_c = (d_state != D_ERR1);
      hresp_c  = (d_state != D_IDLE);
    end else if (t_state == T_ERR1) begin
      hready_c = 1'b0;
      hresp_c  = 1'b1;
    end else if (t_state == T_ERR2) begin
      hresp_c  = 1'b1;
    end else begin
      hready_c = sel_ready;
      hresp_c  = sel_resp;
      hrdata_c = sel_rdata;
    end
  end

  assign accept_unmapped_c = hready_c && !hit && bus.htrans[1];

  // Next-state logic for the default slave and the watchdog
  always_comb begin
    d_next = d_state;
    t_next = t_state;
    case (d_state)
      D_IDLE:  if (accept_unmapped_c) d_next = D_ERR1;
      D_ERR1:  d_next = D_ERR2;
      D_ERR2:  d_next = accept_unmapped_c ? D_ERR1 : D_IDLE;
      default: d_next = D_IDLE;
    endcase
    case (t_state)
      T_IDLE:  if (wd_fire_c) t_next = T_ERR1;
      T_ERR1:  t_next = T_ERR2;
      T_ERR2:  t_next = T_IDLE;
      default: t_next = T_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_state <= D_IDLE;
      t_state <= T_IDLE;
      dsel    <= DEF;
      dvalid  <= 1'b0;
      wcnt    <= '0;
    end else begin
      d_state <= d_next;
      t_state <= t_next;
      if (hready_c) begin
        dsel   <= hit_idx;
        dvalid <= bus.htrans[1];
        wcnt   <= '0;
      end else if (wd_active_c && !sel_ready && (wcnt != WD_MAX)) begin
        wcnt <= wcnt + CNT_W'(1);
      end
    end
  end

  assign bus.hsel     = hsel_c;
  assign bus.hready   = hready_c;
  assign bus.hresp    = hresp_c;
  assign bus.hrdata   = hrdata_c;
  assign timeout_evt  = wd_fire_c;

endmodule

// File: tb/tb_ahb_decode_mux.sv
// Scoreboard bench for ahb_decode_mux: directed per-cycle vectors queue expected
// responses; a negedge monitor pops and compares them.
module tb_ahb_decode_mux;

  localparam logic [1:0]  IDLE   = 2'd0;
  localparam logic [1:0]  NONSEQ = 2'd2;
  localparam logic [1:0]  SEQ    = 2'd3;
  localparam logic [31:0] RD0    = 32'hA000_0000;
  localparam logic [31:0] RD1    = 32'hA000_0001;
  localparam logic [31:0] RD2    = 32'hA000_0002;

  typedef struct packed {
    logic [63:0] name;
    logic [2:0]  hsel;
    logic        hready;
    logic        hresp;
    logic [31:0] hrdata;
    logic        chk_rd;
    logic        tevt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        timeout_evt;
  logic [2:0]  s_rdy, s_rsp, n_rdy, n_rsp;
  logic [31:0] rd1, rd2, n_rd1, n_rd2;
  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  ahb_decode_mux_if #(.N_SLAVES(3)) bus ();

  assign bus.s_hreadyout = s_rdy;
  assign bus.s_hresp     = s_rsp;
  assign bus.s_hrdata    = {rd2, rd1, RD0};

  ahb_decode_mux #(
    .N_SLAVES      (3),
    .SLAVE_BASE    ({32'h0000_1000, 32'h0000_0800, 32'h0000_0000}),
    .SLAVE_SIZE    ({3{32'h0000_0800}}),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .timeout_evt(timeout_evt)
  );

  task automatic chk(input logic [63:0] nm, input string what,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got %h expected %h", nm, what, act, exp);
    end
  endtask

  // One bus cycle: drive master and slave inputs after the edge, queue the expected response
  task automatic cyc(input logic [63:0] nm, input logic r, input logic [31:0] a,
                     input logic [1:0] t, input logic [2:0] eh, input logic er,
                     input logic ep, input logic [31:0] ed, input logic cr, input logic et);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n      = r;
    bus.haddr  = a;
    bus.htrans = t;
    s_rdy      = n_rdy;
    s_rsp      = n_rsp;
    rd1        = n_rd1;
    rd2        = n_rd2;
    e.name   = nm;
    e.hsel   = eh;
    e.hready = er;
    e.hresp  = ep;
    e.hrdata = ed;
    e.chk_rd = cr;
    e.tevt   = et;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk(mon_e.name, "hsel",   32'(bus.hsel),    32'(mon_e.hsel));
      chk(mon_e.name, "hready", 32'(bus.hready),  32'(mon_e.hready));
      chk(mon_e.name, "hresp",  32'(bus.hresp),   32'(mon_e.hresp));
      chk(mon_e.name, "tevt",   32'(timeout_evt), 32'(mon_e.tevt));
      if (mon_e.chk_rd) chk(mon_e.name, "hrdata", bus.hrdata, mon_e.hrdata);
    end
  end

  initial begin
    rst_n = 1'b0; bus.haddr = '0; bus.htrans = IDLE;
    n_rdy = 3'b111; n_rsp = 3'b000; n_rd1 = RD1; n_rd2 = RD2;
    s_rdy = n_rdy; s_rsp = n_rsp; rd1 = n_rd1; rd2 = n_rd2;

    //  name     rst addr           htrans  hsel    rdy   rsp   rdata         chk   tevt
    cyc("rst0",  0, 32'h0000_0000, IDLE,   3'b001, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0);
    cyc("rst1",  0, 32'h0000_0000, IDLE,   3'b001, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0);
    // decode boundaries
    cyc("dec000",1, 32'h0000_0000, NONSEQ, 3'b001, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0);
    cyc("dec7fc",1, 32'h0000_07FC, NONSEQ, 3'b001, 1'b1, 1'b0, RD0,          1'b1, 1'b0);
    cyc("dec800",1, 32'h0000_0800, NONSEQ, 3'b010, 1'b1, 1'b0, RD0,          1'b1, 1'b0);
    cyc("dec17fc",1,32'h0000_17FC, NONSEQ, 3'b100, 1'b1, 1'b0, RD1,          1'b1, 1'b0);
    cyc("decidl",1, 32'h0000_0000, IDLE,   3'b001, 1'b1, 1'b0, RD2,          1'b1, 1'b0);
    // single unmapped access, master stalls with a new address during ERR1
    cyc("um1800",1, 32'h0000_1800, NONSEQ, 3'b000, 1'b1, 1'b0, RD0,          1'b1, 1'b0);
    cyc("umerr1",1, 32'h0000_0000, IDLE,   3'b001, 1'b0, 1'b1, 32'h0,        1'b1, 1'b0);
    cyc("umerr2",1, 32'h0000_0000, IDLE,   3'b001, 1'b1, 1'b1, 32'h0,        1'b1, 1'b0);
    // back-to-back unmapped
    cyc("bb2000",1, 32'h0000_2000, NONSEQ, 3'b000, 1'b1, 1'b0, RD0,          1'b1, 1'b0);
    cyc("bbe1a", 1, 32'h0000_2004, SEQ,    3'b000, 1'b0, 1'b1, 32'h0,        1'b1, 1'b0);
    cyc("bbe2a", 1, 32'h0000_2004, SEQ,    3'b000, 1'b1, 1'b1, 32'h0,        1'b1, 1'b0);
    cyc("bbe1b", 1, 32'h0000_0000, IDLE,   3'b001, 1'b0, 1'b1, 32'h0,        1'b1, 1'b0);
    cyc("bbe2b", 1, 32'h0000_0000, IDLE,   3'b001, 1'b1, 1'b1, 32'h0,        1'b1, 1'b0);
    // three wait states from slave 1
    cyc("ws_adr",1, 32'h0000_0800, NONSEQ, 3'b010, 1'b1, 1'b0, RD0,          1'b1, 1'b0);
    n_rdy = 3'b101;
    cyc("ws1",   1, 32'h0000_0000, IDLE,   3'b001, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0);
    cyc("ws2",   1, 32'h0000_0000, IDLE,   3'b001, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0);
    cyc("ws3",   1, 32'h0000_0000, IDLE,   3'b001, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0);
    n_rdy = 3'b111; n_rd1 = 32'hCAFE_0001;
    cyc("ws_done",1,32'h0000_0000, IDLE,   3'b001, 1'b1, 1'b0, 32'hCAFE_0001,1'b1, 1'b0);
    n_rd1 = RD1;
    // slave 2 stuck low until the watchdog fires
    cyc("to_adr",1, 32'h0000_1000, NONSEQ, 3'b100, 1'b1, 1'b0, RD0,          1'b1, 1'b0);
    n_rdy = 3'b011;
    cyc("to_c1", 1, 32'h0000_0000, IDLE,   3'b001, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0);
    cyc("to_c2", 1, 32'h0000_0000, IDLE,   3'b001, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0);
    cyc("to_c3", 1, 32'h0000_0000, IDLE,   3'b001, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0);
    cyc("to_c4", 1, 32'h0000_0000, IDLE,   3'b001, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1);
    cyc("to_err1",1,32'h0000_0000, IDLE,   3'b001, 1'b0, 1'b1, 32'h0,        1'b1, 1'b0);
    n_rdy = 3'b111;
    cyc("to_err2",1,32'h0000_1000, NONSEQ, 3'b100, 1'b1, 1'b1, 32'h0,        1'b1, 1'b0);
    cyc("to_next",1,32'h0000_0000, IDLE,   3'b001, 1'b1, 1'b0, RD2,          1'b1, 1'b0);
    // slave ERROR passes through untouched
    cyc("se_adr",1, 32'h0000_0800, NONSEQ, 3'b010, 1'b1, 1'b0, RD0,          1'b1, 1'b0);
    n_rdy = 3'b101; n_rsp = 3'b010;
    cyc("se_e1", 1, 32'h0000_0000, IDLE,   3'b001, 1'b0, 1'b1, 32'h0,        1'b0, 1'b0);
    n_rdy = 3'b111;
    cyc("se_e2", 1, 32'h0000_0000, IDLE,   3'b001, 1'b1, 1'b1, RD1,          1'b1, 1'b0);
    n_rsp = 3'b000;
    cyc("se_ok", 1, 32'h0000_0000, IDLE,   3'b001, 1'b1, 1'b0, RD0,          1'b1, 1'b0);
    // reset asserted while the default slave is in ERR1
    cyc("rs_adr",1, 32'h0000_3000, NONSEQ, 3'b000, 1'b1, 1'b0, RD0,          1'b1, 1'b0);
    cyc("rs_on", 0, 32'h0000_0000, IDLE,   3'b001, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0);
    cyc("rs_rel",1, 32'h0000_0000, IDLE,   3'b001, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0);
    cyc("rs_id1",1, 32'h0000_0004, IDLE,   3'b001, 1'b1, 1'b0, RD0,          1'b1, 1'b0);
    cyc("rs_id2",1, 32'h0000_0008, IDLE,   3'b001, 1'b1, 1'b0, RD0,          1'b1, 1'b0);

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
